// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset of a PC; every bit of the input participates.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer holding {pc, instr} pairs, flush beats push
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential PC generation, pipelined imem requests, prefetch buffer, redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FCW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_in;

  // Issue only when a FIFO slot is reserved for every request in flight; the
  // reset term keeps the request low while the async reset is held.
  always_comb begin
    imem_req_valid = reset && !branch_taken
                  && (32'(out_q) < 32'(MAX_OUTSTANDING))
                  && ((32'(out_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_q == '0) && !branch_taken;
    fifo_push      = rsp_keep && (!fifo_full || fifo_pop);
    fifo_pop       = !fifo_empty && instr_ready && !branch_taken;
    fifo_in.pc     = rsp_pc_q;
    fifo_in.instr  = imem_rsp_data;
  end

  // Next-state for PCs and the in-flight / to-be-dropped counters; a redirect
  // overrides everything and converts all surviving in-flight requests to drops.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    if (branch_taken) begin
      fetch_pc_d = align_pc(branch_target);
      rsp_pc_d   = align_pc(branch_target);
      drop_d     = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)                          fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_keep)                          rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && drop_q != '0)    drop_d     = drop_q - CW'(1);
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .flush    (branch_taken),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Decode-facing outputs; payload is forced to zero while nothing is buffered.
  always_comb begin
    instr_valid = !fifo_empty;
    instr       = fifo_empty ? '0 : fifo_head.instr;
    instr_pc    = fifo_empty ? '0 : fifo_head.pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-based reference
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC       (RESET_PC),
    .FIFO_DEPTH     (DEPTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        pending[$];
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  int          cyc;
  int          n_chk;
  int          n_pass;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF8;
      2:       return 32'h0000_0040;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    instr_ready    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},    imem_req_addr, RESET_PC);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"},       instr, 32'd0);
    chk({tag, "_instr_pc"},    instr_pc, 32'd0);
  endtask

  // One clock: drive at the falling edge, check, then advance the reference
  // to the state it must hold after the coming rising edge.
  task automatic step(input int p_ready, input int p_irdy, input int p_rsp, input int p_br);
    bit          br, rsp, rdy, exp_rv, popped;
    logic [31:0] tgt;
    req_t        r;
    ent_t        e;
    @(negedge clk);
    cyc++;
    br  = ($urandom_range(99) < p_br);
    tgt = pick_target();
    rdy = ($urandom_range(99) < p_ready);
    rsp = (pending.size() > 0) && (pending[0].cyc < cyc) && ($urandom_range(99) < p_rsp);
    assert (!rsp || pending.size() > 0) else $error("response with nothing outstanding");
    branch_taken   = br;
    branch_target  = tgt;
    imem_req_ready = rdy;
    instr_ready    = ($urandom_range(99) < p_irdy);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pending[0].addr) : $urandom;
    #1;
    exp_rv = !br && (pending.size() < MAX_OUT) && (pending.size() + exp_q.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, model_pc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("instr_pc", instr_pc, exp_q[0].pc);
      chk("instr", instr, exp_q[0].data);
    end
    popped = (exp_q.size() > 0) && instr_ready;
    if (br) begin
      exp_q.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      model_pc = tgt & ~32'h3;
    end
    if (rsp) begin
      r = pending.pop_front();
      if (!br && popped) void'(exp_q.pop_front());
      if (!r.stale) begin
        e.pc   = r.addr;
        e.data = mem_word(r.addr);
        exp_q.push_back(e);
      end
    end else if (!br && popped) begin
      void'(exp_q.pop_front());
    end
    if (exp_rv && rdy) begin
      r.addr  = model_pc;
      r.stale = 1'b0;
      r.cyc   = cyc;
      pending.push_back(r);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic run(input int n, input int p_ready, input int p_irdy, input int p_rsp, input int p_br);
    for (int i = 0; i < n; i++) step(p_ready, p_irdy, p_rsp, p_br);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs("midrst");
    pending.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    cyc      = 0;
    model_pc = RESET_PC;
    rst_n    = 1'b0;
    drive_idle();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(20, 100, 100, 100, 0);
    run(30, 100, 0, 100, 0);
    run(20, 100, 100, 100, 0);
    run(40, 30, 100, 100, 0);
    run(400, 60, 70, 60, 8);
    run(6, 100, 100, 100, 0);
    mid_reset();
    run(400, 50, 50, 50, 15);
    run(200, 80, 80, 80, 30);
    run(40, 100, 100, 100, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
